// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: FSM states, MIPS
// opcode/funct fields, ALU operation codes and datapath mux select codes.
package multicycle_ctrl_pkg;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEM_ADR = 4'd3;
  localparam logic [3:0] S_MEM_RD  = 4'd4;
  localparam logic [3:0] S_MEM_WB  = 4'd5;
  localparam logic [3:0] S_MEM_WR  = 4'd6;
  localparam logic [3:0] S_R_EXE   = 4'd7;
  localparam logic [3:0] S_R_WB    = 4'd8;
  localparam logic [3:0] S_I_EXE   = 4'd9;
  localparam logic [3:0] S_I_WB    = 4'd10;
  localparam logic [3:0] S_BRANCH  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_NOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the control unit.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] ALUOp;
  logic       illegal;
  logic       bus_err;

  modport master (
    input  opcode, funct, Zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, ALUOp, illegal, bus_err
  );

  modport slave (
    output opcode, funct, Zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, ALUOp, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational opcode/funct -> ALU operation map with a legality flag.
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        valid = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: valid  = 1'b0;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; valid = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; valid = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  valid = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; valid = 1'b1; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: instruction sequencing, datapath strobes and
// memory handshake with a wait-cycle timeout that aborts back to FETCH.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);

  logic [3:0] state, next_state;
  logic [5:0] op_q;
  logic [2:0] alu_q;
  logic [7:0] wait_cnt;
  logic       abort;
  logic [2:0] dec_op;
  logic       dec_valid;
  logic       timeout_hit;

  logic       mreq, mwe, iord, irw, pcw, rw, rdst, m2r, sa, ill, berr;
  logic [1:0] sb, ps;
  logic [2:0] aop;

  alu_op_decode u_alu_op_decode (
    .opcode (op_q),
    .funct  (bus.funct),
    .alu_op (dec_op),
    .valid  (dec_valid)
  );

  // abort marks the cycle after a timeout: request dropped, error pulsed
  assign timeout_hit = mreq && !bus.mem_ready && (wait_cnt == 8'(MEM_TIMEOUT));

  always_comb begin
    next_state = state;
    mreq = 1'b0; mwe  = 1'b0; iord = 1'b0; irw = 1'b0; pcw = 1'b0;
    rw   = 1'b0; rdst = 1'b0; m2r  = 1'b0; sa  = 1'b0; ill = 1'b0; berr = 1'b0;
    sb   = SRCB_B;
    ps   = PCSRC_ALU;
    aop  = ALU_ADD;
    if (abort) begin
      berr       = 1'b1;
      next_state = S_FETCH;
    end else begin
      case (state)
        S_IDLE: next_state = S_FETCH;
        S_FETCH: begin
          mreq = 1'b1;
          sb   = SRCB_FOUR;
          if (bus.mem_ready) begin
            irw        = 1'b1;
            pcw        = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          sb = SRCB_IMM_SH;
          case (bus.opcode)
            OP_LW, OP_SW:                     next_state = S_MEM_ADR;
            OP_RTYPE:                         next_state = S_R_EXE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_I_EXE;
            OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
            OP_J:                             next_state = S_JUMP;
            default: begin
              ill        = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_MEM_ADR: begin
          sa         = 1'b1;
          sb         = SRCB_IMM;
          next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mreq = 1'b1;
          iord = 1'b1;
          if (bus.mem_ready) next_state = S_MEM_WB;
        end
        S_MEM_WB: begin
          rw         = 1'b1;
          m2r        = 1'b1;
          next_state = S_FETCH;
        end
        S_MEM_WR: begin
          mreq = 1'b1;
          mwe  = 1'b1;
          iord = 1'b1;
          if (bus.mem_ready) next_state = S_FETCH;
        end
        S_R_EXE: begin
          sa  = 1'b1;
          aop = dec_op;
          if (dec_valid) next_state = S_R_WB;
          else begin
            ill        = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_R_WB: begin
          rw         = 1'b1;
          rdst       = 1'b1;
          aop        = alu_q;
          next_state = S_FETCH;
        end
        S_I_EXE: begin
          sa         = 1'b1;
          sb         = SRCB_IMM;
          aop        = dec_op;
          next_state = S_I_WB;
        end
        S_I_WB: begin
          rw         = 1'b1;
          aop        = alu_q;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          sa         = 1'b1;
          aop        = ALU_SUB;
          ps         = PCSRC_ALUOUT;
          pcw        = ((op_q == OP_BEQ) && bus.Zero) || ((op_q == OP_BNE) && !bus.Zero);
          next_state = S_FETCH;
        end
        S_JUMP: begin
          ps         = PCSRC_JUMP;
          pcw        = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      alu_q    <= ALU_ADD;
      wait_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      state <= next_state;
      abort <= timeout_hit;
      if (state == S_DECODE) op_q <= bus.opcode;
      if (state == S_R_EXE || state == S_I_EXE) alu_q <= dec_op;
      // any cycle without an outstanding stalled request restarts the count
      if (mreq && !bus.mem_ready && !timeout_hit) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= '0;
    end
  end

  assign bus.mem_req    = mreq;
  assign bus.mem_we     = mwe;
  assign bus.iord       = iord;
  assign bus.ir_write   = irw;
  assign bus.pc_write   = pcw;
  assign bus.reg_write  = rw;
  assign bus.reg_dst    = rdst;
  assign bus.mem_to_reg = m2r;
  assign bus.alu_src_a  = sa;
  assign bus.alu_src_b  = sb;
  assign bus.pc_source  = ps;
  assign bus.ALUOp      = aop;
  assign bus.illegal    = ill;
  assign bus.bus_err    = berr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table for each
// instruction class plus hand sequences for wait states, timeout and reset.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if intf ();

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf.master)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [17:0] want;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [17:0] outs;
  assign outs = {intf.mem_req, intf.mem_we, intf.iord, intf.ir_write, intf.pc_write,
                 intf.reg_write, intf.reg_dst, intf.mem_to_reg, intf.alu_src_a,
                 intf.alu_src_b, intf.pc_source, intf.ALUOp, intf.illegal, intf.bus_err};

  function automatic logic [17:0] ex(input logic mreq, mwe, io, irw, pcw, rw, rd, m2r, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] aop,
                                     input logic ill, be);
    return {mreq, mwe, io, irw, pcw, rw, rd, m2r, sa, sb, ps, aop, ill, be};
  endfunction

  function automatic logic [17:0] e_fetch(input logic r);
    return ex(1, 0, 0, r, r, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_dec(input logic ill);
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, ill, 0);
  endfunction
  function automatic logic [17:0] e_madr();
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_mrd();
    return ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_mwb();
    return ex(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_mwr();
    return ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_rexe(input logic [2:0] aop, input logic ill);
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aop, ill, 0);
  endfunction
  function automatic logic [17:0] e_rwb(input logic [2:0] aop);
    return ex(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, aop, 0, 0);
  endfunction
  function automatic logic [17:0] e_iexe(input logic [2:0] aop);
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, aop, 0, 0);
  endfunction
  function automatic logic [17:0] e_iwb(input logic [2:0] aop);
    return ex(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, aop, 0, 0);
  endfunction
  function automatic logic [17:0] e_br(input logic pcw);
    return ex(0, 0, 0, 0, pcw, 0, 0, 0, 1, 2'b00, 2'b01, 3'b101, 0, 0);
  endfunction
  function automatic logic [17:0] e_jmp();
    return ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_berr();
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);
  endfunction

  function automatic vec_t mk(input logic [5:0] op, fn, input logic z, rdy,
                              input logic [17:0] want);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.want = want;
    return v;
  endfunction

  task automatic check(input string name, input logic [17:0] act, want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, want);
    end
  endtask

  task automatic drive(input logic [5:0] op, fn, input logic z, rdy);
    intf.opcode    = op;
    intf.funct     = fn;
    intf.Zero      = z;
    intf.mem_ready = rdy;
  endtask

  task automatic step(input string name, input logic [5:0] op, fn, input logic z, rdy,
                      input logic [17:0] want);
    drive(op, fn, z, rdy);
    #1;
    check(name, outs, want);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_outs", outs, 18'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [5:0] r_fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [2:0] r_aop [6] = '{3'b000,    3'b101,    3'b001,    3'b100,    3'b010,    3'b011};
  logic [5:0] i_op  [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
  logic [2:0] i_aop [4] = '{3'b000,    3'b001,    3'b100,    3'b011};
  logic [5:0] b_op  [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
  logic       b_z   [4] = '{1'b1,      1'b0,      1'b1,      1'b0};
  logic       b_pcw [4] = '{1'b1,      1'b0,      1'b0,      1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Continuous instruction stream, one vector per clock, starting in IDLE.
    tbl.push_back(mk(6'd0, 6'd0, 0, 0, 18'd0));
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk(6'd0, r_fn[i], 0, 1, e_fetch(1)));
      tbl.push_back(mk(6'd0, r_fn[i], 0, 1, e_dec(0)));
      tbl.push_back(mk(6'd0, r_fn[i], 0, 1, e_rexe(r_aop[i], 0)));
      // funct changes after execute; the write-back ALUOp must not follow it
      tbl.push_back(mk(6'd0, 6'b100111 ^ r_fn[i], 0, 1, e_rwb(r_aop[i])));
    end
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(i_op[i], 6'd0, 0, 1, e_fetch(1)));
      tbl.push_back(mk(i_op[i], 6'd0, 0, 1, e_dec(0)));
      tbl.push_back(mk(6'd0, 6'd0, 0, 1, e_iexe(i_aop[i])));
      tbl.push_back(mk(6'd0, 6'd0, 0, 1, e_iwb(i_aop[i])));
    end
    tbl.push_back(mk(6'b100011, 6'd0, 0, 1, e_fetch(1)));
    tbl.push_back(mk(6'b100011, 6'd0, 0, 1, e_dec(0)));
    tbl.push_back(mk(6'b100011, 6'd0, 0, 1, e_madr()));
    tbl.push_back(mk(6'b100011, 6'd0, 0, 1, e_mrd()));
    tbl.push_back(mk(6'b100011, 6'd0, 0, 1, e_mwb()));
    tbl.push_back(mk(6'b101011, 6'd0, 0, 1, e_fetch(1)));
    tbl.push_back(mk(6'b101011, 6'd0, 0, 1, e_dec(0)));
    tbl.push_back(mk(6'b101011, 6'd0, 0, 1, e_madr()));
    tbl.push_back(mk(6'b101011, 6'd0, 0, 1, e_mwr()));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(b_op[i], 6'd0, 0, 1, e_fetch(1)));
      tbl.push_back(mk(b_op[i], 6'd0, 0, 1, e_dec(0)));
      tbl.push_back(mk(b_op[i], 6'd0, b_z[i], 1, e_br(b_pcw[i])));
    end
    tbl.push_back(mk(6'b000010, 6'd0, 0, 1, e_fetch(1)));
    tbl.push_back(mk(6'b000010, 6'd0, 0, 1, e_dec(0)));
    tbl.push_back(mk(6'b000010, 6'd0, 0, 1, e_jmp()));
    tbl.push_back(mk(6'b111111, 6'd0, 0, 1, e_fetch(1)));
    tbl.push_back(mk(6'b111111, 6'd0, 0, 1, e_dec(1)));
    tbl.push_back(mk(6'd0, 6'b000111, 0, 1, e_fetch(1)));
    tbl.push_back(mk(6'd0, 6'b000111, 0, 1, e_dec(0)));
    tbl.push_back(mk(6'd0, 6'b000111, 0, 1, e_rexe(3'b000, 1)));
    tbl.push_back(mk(6'd0, 6'd0, 0, 0, e_fetch(0)));

    do_reset();
    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy, tbl[i].want);

    // lw with three wait cycles on both accesses: 11 cycles FETCH..MEM_WB
    do_reset();
    step("lw_idle", 6'b100011, 6'd0, 0, 0, 18'd0);
    for (int i = 0; i < 3; i++) step("lw_fetch_wait", 6'b100011, 6'd0, 0, 0, e_fetch(0));
    step("lw_fetch_done", 6'b100011, 6'd0, 0, 1, e_fetch(1));
    step("lw_dec", 6'b100011, 6'd0, 0, 0, e_dec(0));
    step("lw_adr", 6'b100011, 6'd0, 0, 0, e_madr());
    for (int i = 0; i < 3; i++) step("lw_rd_wait", 6'b100011, 6'd0, 0, 0, e_mrd());
    step("lw_rd_done", 6'b100011, 6'd0, 0, 1, e_mrd());
    step("lw_wb", 6'b100011, 6'd0, 0, 0, e_mwb());
    step("lw_next_fetch", 6'b100011, 6'd0, 0, 0, e_fetch(0));

    // sw timeout: five request cycles, bus_err on the sixth, ready there ignored
    do_reset();
    step("swto_idle", 6'b101011, 6'd0, 0, 0, 18'd0);
    step("swto_fetch", 6'b101011, 6'd0, 0, 1, e_fetch(1));
    step("swto_dec", 6'b101011, 6'd0, 0, 1, e_dec(0));
    step("swto_adr", 6'b101011, 6'd0, 0, 1, e_madr());
    for (int i = 0; i < 5; i++) step("swto_wr_wait", 6'b101011, 6'd0, 0, 0, e_mwr());
    step("swto_bus_err", 6'b101011, 6'd0, 0, 1, e_berr());
    step("swto_refetch", 6'b101011, 6'd0, 0, 1, e_fetch(1));

    // aborted FETCH: no ir/pc write, then a fresh FETCH
    do_reset();
    step("fto_idle", 6'd0, 6'd0, 0, 0, 18'd0);
    for (int i = 0; i < 5; i++) step("fto_fetch_wait", 6'd0, 6'd0, 0, 0, e_fetch(0));
    step("fto_bus_err", 6'd0, 6'd0, 0, 0, e_berr());
    step("fto_refetch", 6'd0, 6'd0, 0, 0, e_fetch(0));

    // ready arriving exactly in the timeout cycle completes the read
    do_reset();
    step("rdlast_idle", 6'b100011, 6'd0, 0, 0, 18'd0);
    step("rdlast_fetch", 6'b100011, 6'd0, 0, 1, e_fetch(1));
    step("rdlast_dec", 6'b100011, 6'd0, 0, 1, e_dec(0));
    step("rdlast_adr", 6'b100011, 6'd0, 0, 1, e_madr());
    for (int i = 0; i < 4; i++) step("rdlast_wait", 6'b100011, 6'd0, 0, 0, e_mrd());
    step("rdlast_done", 6'b100011, 6'd0, 0, 1, e_mrd());
    step("rdlast_wb", 6'b100011, 6'd0, 0, 0, e_mwb());

    // asynchronous reset while a read request is outstanding
    do_reset();
    step("arst_idle", 6'b100011, 6'd0, 0, 0, 18'd0);
    step("arst_fetch", 6'b100011, 6'd0, 0, 1, e_fetch(1));
    step("arst_dec", 6'b100011, 6'd0, 0, 1, e_dec(0));
    step("arst_adr", 6'b100011, 6'd0, 0, 1, e_madr());
    drive(6'b100011, 6'd0, 0, 0);
    #1;
    check("arst_rd_req", outs, e_mrd());
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs_zero", outs, 18'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("arst_post_idle", 6'b100011, 6'd0, 0, 0, 18'd0);
    step("arst_post_fetch", 6'b100011, 6'd0, 0, 0, e_fetch(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit for the multi-cycle CPU datapath. Decodes the fetched MIPS instruction, sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several cycles, and drives the datapath muxes, the register-file and memory strobes, and the 3-bit ALU operation code. It consumes the ALU `Zero` flag to resolve branches and runs a ready/request handshake with the unified instruction/data memory.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles for `mem_ready` before abort (1..255).
- `clk  in  1`: system clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `opcode  in  6`: IR[31:26].
- `funct  in  6`: IR[5:0].
- `Zero  in  1`: ALU zero flag, combinational from the ALU in the same cycle.
- `mem_ready  in  1`: memory completes the current request this cycle.
- `mem_req  out  1`: memory request, held until `mem_ready` or timeout.
- `mem_we  out  1`: write qualifier for `mem_req`.
- `iord  out  1`: 0 = PC addresses memory, 1 = ALUOut.
- `ir_write  out  1`: load IR.
- `pc_write  out  1`: load PC.
- `reg_write  out  1`: register file write.
- `reg_dst  out  1`: 0 = rt, 1 = rd.
- `mem_to_reg  out  1`: 0 = ALUOut, 1 = MDR.
- `alu_src_a  out  1`: 0 = PC, 1 = register A.
- `alu_src_b  out  2`: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pc_source  out  2`: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp  out  3`: 000 add, 101 sub, 001 and, 010 nor, 011 slt, 100 or.
- `illegal  out  1`: one-cycle pulse on an unsupported opcode/funct.
- `bus_err  out  1`: one-cycle pulse on memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, I_EXE, I_WB, BRANCH, JUMP.
- IDLE: all outputs 0. Moves unconditionally to FETCH.
- FETCH: `mem_req`=1, `iord`=0, A=PC, B=4, add, `pc_source`=00. When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 in that cycle, then DECODE.
- DECODE: A=PC, B=imm<<2, add (branch target into ALUOut). Next state by opcode:
  - 100011/101011 (lw/sw) → MEM_ADR
  - 000000 → R_EXE
  - 001000/001100/001101/001010 (addi/andi/ori/slti) → I_EXE
  - 000100/000101 (beq/bne) → BRANCH
  - 000010 (j) → JUMP
  - anything else → `illegal` pulse, FETCH.
- MEM_ADR: A=reg, B=imm, add. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_req`=1, `iord`=1; on `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1; on `mem_ready` → FETCH.
- R_EXE: A=reg, B=B. funct map: 100000→000, 100010→101, 100100→001, 100101→100, 100111→010, 101010→011. Other funct: `illegal` pulse, go to FETCH, no write. Valid funct → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `ALUOp` held → FETCH.
- I_EXE: A=reg, B=imm. addi→000, andi→001, ori→100, slti→011 → I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, ALUOp held → FETCH.
- BRANCH: A=reg, B=B, sub, `pc_source`=01. `pc_write` = (beq & Zero) | (bne & ~Zero) → FETCH.
- JUMP: `pc_source`=10, `pc_write`=1 → FETCH.
- Opcode is latched in DECODE; funct in R_EXE uses the live IR value, which is stable after DECODE.

## Timing
- Reset (async, mid-operation included): state=IDLE, wait counter=0, every output 0 immediately. First FETCH occurs in the second cycle after deassertion.
- Outputs are Moore decodes of the state, except three: `ir_write`/`pc_write` in FETCH (gated by `mem_ready`) and `pc_write` in BRANCH (from `Zero`).
- Latency with zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3. Each `mem_ready` wait cycle adds one.
- Wait counter: 8 bits. Cleared on entering any memory state. Increments on each cycle with `mem_req`=1 and `mem_ready`=0.
- Timeout: counter == `MEM_TIMEOUT`. Next cycle: `mem_req` drops, `bus_err` pulses, state goes to FETCH. PC and registers are unchanged in an aborted FETCH.
- `mem_ready` while `mem_req`=0 is ignored. `mem_ready` in the timeout cycle counts as completion.

## Structure
- A shared package holds:
  - state encoding (localparam enum)
  - opcode, funct and ALUOp constants, which are shared with the ALU
  - `alu_src_b`/`pc_source` codes
- One sub-module, `alu_op_decode`: combinational funct/opcode → ALUOp plus a valid flag. FSM, counter and output decode stay in `multicycle_ctrl`.

## Test plan
- add (opcode 0, funct 100000), `mem_ready` tied 1 → FETCH, DECODE, R_EXE (ALUOp=000), R_WB (`reg_write`=1, `reg_dst`=1) → FETCH in 4 cycles.
- lw with `mem_ready` delayed 3 cycles on each access → `mem_req` held 4 cycles in FETCH and in MEM_RD. MEM_WB `mem_to_reg`=1; total 11 cycles.
- beq: Zero=1 → `pc_write`=1, `pc_source`=01. Zero=0 → `pc_write`=0. bne: the inverse of each.
- Opcode 111111 → `illegal`=1 for one cycle in DECODE, next state FETCH, no `reg_write`. R-type funct 000111 → `illegal` in R_EXE.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 in MEM_WR → `bus_err` pulse on the 6th cycle of `mem_req`, no `reg_write`, return to FETCH.
- `rst_n` low during MEM_RD with `mem_req`=1 → all outputs 0 asynchronously. After release: IDLE, then FETCH with `mem_req`=1.
